// File: rtl/load_store_align_unit.sv
// ============================================================================
// load_store_align_unit: byte/half/word load-store alignment between the core
// and a word-only memory port; sub-word stores via read-modify-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_align_unit #(
   parameter logic FAULT_ON_UNSELECTED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_address,
   input  logic [31:0] req_write_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_read_data,
   output logic        resp_fault,
   output logic        mem_rw,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        mem_selected
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  r_state;
   logic        r_rw;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_fault;

   logic        w_misaligned;
   logic        w_illegal;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
   assign w_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111) || (req_rw && req_funct3[2]);

   // Lane extraction for loads and lane replacement for sub-word stores
   always_comb begin
      w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = mem_read_data;
      endcase
      w_merge = mem_read_data;
      if (r_funct3[1:0] == 2'b00) begin
         w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end else begin
         w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rw     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_rdata  <= 32'd0;
         r_fault  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_rw     <= req_rw;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_address;
                  r_wdata  <= req_write_data;
                  r_rdata  <= 32'd0;
                  r_fault  <= 1'b0;
                  if (w_misaligned || w_illegal) begin
                     r_fault <= 1'b1;
                     r_state <= S_RESP;
                  end else if (!req_rw || (req_funct3[1:0] != 2'b10)) begin
                     r_state <= S_RD;
                  end else begin
                     r_state <= S_WR;
                  end
               end
            end
            S_RD: begin
               if (!mem_selected) begin
                  r_fault <= FAULT_ON_UNSELECTED;
                  r_rdata <= 32'd0;
                  r_state <= S_RESP;
               end else if (!r_rw) begin
                  r_rdata <= w_load;
                  r_state <= S_RESP;
               end else begin
                  r_wdata <= w_merge;
                  r_state <= S_WR;
               end
            end
            S_WR: begin
               if (!mem_selected) begin
                  r_fault <= FAULT_ON_UNSELECTED;
               end
               r_state <= S_RESP;
            end
            default: begin
               if (resp_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready      = (r_state == S_IDLE);
   assign resp_valid     = (r_state == S_RESP);
   assign resp_read_data = r_rdata;
   assign resp_fault     = r_fault;
   // Gated by rst so an aborted write never reaches memory
   assign mem_rw         = (r_state == S_WR) && mem_selected && !rst;
   assign mem_address    = {r_addr[31:2], 2'b00};
   assign mem_write_data = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_align_unit.sv
// ============================================================================
// tb_load_store_align_unit: directed and randomized checks of the load/store
// alignment unit against a byte-lane reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_align_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_rw = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_address = 32'd0;
   logic [31:0] req_write_data = 32'd0;
   logic        resp_ready = 1'b0;
   logic        req_ready, resp_valid, resp_fault, mem_rw, mem_selected;
   logic [31:0] resp_read_data, mem_address, mem_write_data, mem_read_data;

   logic        u_req_valid = 1'b0;
   logic        u_req_rw = 1'b0;
   logic [2:0]  u_req_funct3 = 3'd0;
   logic [31:0] u_req_address = 32'd0;
   logic [31:0] u_req_write_data = 32'd0;
   logic        u_resp_ready = 1'b0;
   logic        u_req_ready, u_resp_valid, u_resp_fault, u_mem_rw;
   logic [31:0] u_resp_read_data, u_mem_address, u_mem_write_data;

   logic [31:0] mem [0:15];
   logic [31:0] ref_mem [0:15];
   logic [31:0] last_wdata = 32'd0;
   int          wr_count = 0;
   int          u_wr_count = 0;
   int          rst_wr = 0;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   load_store_align_unit #(.FAULT_ON_UNSELECTED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_read_data(resp_read_data), .resp_fault(resp_fault),
      .mem_rw(mem_rw), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_selected(mem_selected)
   );

   load_store_align_unit #(.FAULT_ON_UNSELECTED(1'b0)) dut_u (
      .clk(clk), .rst(rst),
      .req_valid(u_req_valid), .req_ready(u_req_ready), .req_rw(u_req_rw),
      .req_funct3(u_req_funct3), .req_address(u_req_address), .req_write_data(u_req_write_data),
      .resp_valid(u_resp_valid), .resp_ready(u_resp_ready),
      .resp_read_data(u_resp_read_data), .resp_fault(u_resp_fault),
      .mem_rw(u_mem_rw), .mem_address(u_mem_address), .mem_write_data(u_mem_write_data),
      .mem_read_data(32'hFFFF_FFFF), .mem_selected(1'b0)
   );

   // Memory occupies 0x80000000..0x8000003F; everything else is unselected
   assign mem_selected  = (mem_address >= 32'h8000_0000) && (mem_address < 32'h8000_0040);
   assign mem_read_data = mem_selected ? mem[mem_address[5:2]] : 32'd0;

   always @(posedge clk) begin
      if (mem_rw) begin
         wr_count   <= wr_count + 1;
         last_wdata <= mem_write_data;
         if (mem_selected) mem[mem_address[5:2]] <= mem_write_data;
         if (rst) rst_wr <= rst_wr + 1;
      end
      if (u_mem_rw) u_wr_count <= u_wr_count + 1;
   end

   task automatic ref_access(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                             output int lat, output int nwr);
      int nbytes, ofs, idx;
      bit legal;
      longint unsigned field, mask;
      rd = 32'd0; flt = 1'b0; nwr = 0; lat = 1;
      legal  = rw ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      nbytes = 1 << f3[1:0];
      ofs    = int'(a % 32'd4);
      if (!legal || (ofs % nbytes) != 0) begin
         flt = 1'b1;
         return;
      end
      lat = 2;
      if (a < 32'h8000_0000 || a >= 32'h8000_0040) begin
         flt = 1'b1;
         return;
      end
      idx  = int'((a - 32'h8000_0000) / 32'd4);
      mask = ((64'd1 << (8 * nbytes)) - 64'd1) << (8 * ofs);
      if (!rw) begin
         field = ({32'd0, ref_mem[idx]} & mask) >> (8 * ofs);
         if (!f3[2] && nbytes < 4 && field[8 * nbytes - 1])
            field = field | ~((64'd1 << (8 * nbytes)) - 64'd1);
         rd = field[31:0];
      end else begin
         field = ({32'd0, ref_mem[idx]} & ~mask) | (({32'd0, wd} << (8 * ofs)) & mask);
         ref_mem[idx] = field[31:0];
         nwr = 1;
         lat = (nbytes == 4) ? 2 : 3;
      end
   endtask

   task automatic issue(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_rw = rw; req_funct3 = f3; req_address = a; req_write_data = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic run_req(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat, output int nwr);
      int w0;
      w0 = wr_count;
      issue(rw, f3, a, wd);
      wait_valid(lat);
      rd = resp_read_data; flt = resp_fault; nwr = wr_count - w0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
      n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
      n_total++; if ({resp_fault, resp_read_data} !== 33'd0) $display("FAIL reset_resp got=%h exp=0", {resp_fault, resp_read_data}); else n_pass++;
      n_total++; if ({mem_rw, mem_address, mem_write_data} !== 65'd0) $display("FAIL reset_mem got=%h exp=0", {mem_rw, mem_address, mem_write_data}); else n_pass++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_load_ext();
      logic [31:0] rd; logic flt; int lat, nwr;
      mem[4] = 32'h8899_AABB;
      run_req(1'b0, 3'b000, 32'h8000_0011, 32'd0, rd, flt, lat, nwr);
      n_total++; if (rd !== 32'hFFFF_FFAA || flt !== 1'b0) $display("FAIL lb_data got=%h/%b exp=ffffffaa/0", rd, flt); else n_pass++;
      n_total++; if (lat !== 2) $display("FAIL lb_latency got=%0d exp=2", lat); else n_pass++;
      run_req(1'b0, 3'b100, 32'h8000_0011, 32'd0, rd, flt, lat, nwr);
      n_total++; if (rd !== 32'h0000_00AA || flt !== 1'b0) $display("FAIL lbu_data got=%h/%b exp=000000aa/0", rd, flt); else n_pass++;
   endtask

   task automatic test_sub_store();
      logic [31:0] rd; logic flt; int lat, nwr;
      mem[4] = 32'h1122_3344;
      run_req(1'b1, 3'b000, 32'h8000_0012, 32'h0000_005C, rd, flt, lat, nwr);
      n_total++; if (nwr !== 1) $display("FAIL sb_write_count got=%0d exp=1", nwr); else n_pass++;
      n_total++; if (last_wdata !== 32'h115C_3344) $display("FAIL sb_merge got=%h exp=115c3344", last_wdata); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL sb_latency got=%0d exp=3", lat); else n_pass++;
      run_req(1'b0, 3'b010, 32'h8000_0010, 32'd0, rd, flt, lat, nwr);
      n_total++; if (rd !== 32'h115C_3344) $display("FAIL back_to_back_lw got=%h exp=115c3344", rd); else n_pass++;
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic flt; int lat, nwr;
      mem[0] = 32'hCAFE_F00D;
      run_req(1'b1, 3'b001, 32'h8000_0003, 32'h0000_1234, rd, flt, lat, nwr);
      n_total++; if (flt !== 1'b1 || lat !== 1 || nwr !== 0) $display("FAIL sh_misaligned got=%b/%0d/%0d exp=1/1/0", flt, lat, nwr); else n_pass++;
      run_req(1'b0, 3'b010, 32'h8000_0002, 32'd0, rd, flt, lat, nwr);
      n_total++; if (flt !== 1'b1 || lat !== 1 || rd !== 32'd0) $display("FAIL lw_misaligned got=%b/%0d/%h exp=1/1/0", flt, lat, rd); else n_pass++;
      n_total++; if (mem[0] !== 32'hCAFE_F00D) $display("FAIL misaligned_mem got=%h exp=cafef00d", mem[0]); else n_pass++;
   endtask

   task automatic test_unselected();
      logic [31:0] rd; logic flt; int lat, nwr, guard, w0;
      run_req(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, rd, flt, lat, nwr);
      n_total++; if (flt !== 1'b1 || nwr !== 0) $display("FAIL unsel_fault1 got=%b/%0d exp=1/0", flt, nwr); else n_pass++;
      w0 = u_wr_count;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         u_req_valid = 1'b1; u_req_rw = (k == 0); u_req_funct3 = 3'b010;
         u_req_address = 32'h0000_0100; u_req_write_data = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         u_req_valid = 1'b0;
         guard = 0;
         while (!u_resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
         n_total++; if (u_resp_fault !== 1'b0 || u_resp_read_data !== 32'd0 || !u_resp_valid)
            $display("FAIL unsel_param0_%0d got=%b/%h/%b exp=0/0/1", k, u_resp_fault, u_resp_read_data, u_resp_valid);
         else n_pass++;
         u_resp_ready = 1'b1; @(posedge clk); #1; u_resp_ready = 1'b0;
      end
      n_total++; if (u_wr_count !== w0) $display("FAIL unsel_param0_write got=%0d exp=%0d", u_wr_count, w0); else n_pass++;
   endtask

   task automatic test_hold();
      int lat;
      mem[8] = 32'h1234_8001;
      issue(1'b0, 3'b001, 32'h8000_0020, 32'd0);
      wait_valid(lat);
      for (int k = 0; k < 5; k++) begin
         n_total++; if (resp_valid !== 1'b1 || resp_read_data !== 32'hFFFF_8001 || req_ready !== 1'b0)
            $display("FAIL hold_%0d got=%b/%h/%b exp=1/ffff8001/0", k, resp_valid, resp_read_data, req_ready);
         else n_pass++;
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      n_total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold_release got=%b/%b exp=0/1", resp_valid, req_ready); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic flt; int lat, nwr, w0;
      mem[5] = 32'h1122_3344;
      issue(1'b1, 3'b000, 32'h8000_0015, 32'h0000_00AB);
      @(posedge clk); #1;
      n_total++; if (mem_rw !== 1'b1) $display("FAIL mid_wr_reached got=%b exp=1", mem_rw); else n_pass++;
      rst = 1'b1; #1;
      n_total++; if ({mem_rw, mem_address, mem_write_data, resp_valid, resp_fault, resp_read_data, req_ready} !== {66'd0, 33'd0, 1'b1})
         $display("FAIL mid_reset_outputs got=%b%h%h%b%b%h%b exp=reset", mem_rw, mem_address, mem_write_data, resp_valid, resp_fault, resp_read_data, req_ready);
      else n_pass++;
      w0 = wr_count;
      @(posedge clk); #1;
      n_total++; if (wr_count !== w0 || mem[5] !== 32'h1122_3344 || rst_wr !== 0)
         $display("FAIL mid_reset_write got=%0d/%h exp=%0d/11223344", wr_count, mem[5], w0);
      else n_pass++;
      @(negedge clk); rst = 1'b0;
      run_req(1'b0, 3'b010, 32'h8000_0014, 32'd0, rd, flt, lat, nwr);
      n_total++; if (rd !== 32'h1122_3344 || flt !== 1'b0 || lat !== 2) $display("FAIL after_reset_lw got=%h/%b/%0d exp=11223344/0/2", rd, flt, lat); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd; logic flt, eflt, rw; logic [2:0] f3;
      int lat, elat, nwr, enwr;
      for (int i = 0; i < 16; i++) begin
         a = $urandom; mem[i] = a; ref_mem[i] = a;
      end
      for (int n = 0; n < 60; n++) begin
         rw = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 7) == 0) ? 32'h0000_0100 + $urandom_range(0, 15)
                                          : 32'h8000_0000 + $urandom_range(0, 63);
         wd = $urandom;
         ref_access(rw, f3, a, wd, erd, eflt, elat, enwr);
         run_req(rw, f3, a, wd, rd, flt, lat, nwr);
         n_total++; if (rd !== erd || flt !== eflt) $display("FAIL rnd_resp_%0d got=%h/%b exp=%h/%b", n, rd, flt, erd, eflt); else n_pass++;
         n_total++; if (lat !== elat || nwr !== enwr) $display("FAIL rnd_timing_%0d got=%0d/%0d exp=%0d/%0d", n, lat, nwr, elat, enwr); else n_pass++;
      end
      for (int i = 0; i < 16; i++) begin
         n_total++; if (mem[i] !== ref_mem[i]) $display("FAIL rnd_mem_%0d got=%h exp=%h", i, mem[i], ref_mem[i]); else n_pass++;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      test_reset();
      test_load_ext();
      test_sub_store();
      test_faults();
      test_unselected();
      test_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/load_store_align_unit.md
Name: load_store_align_unit

Overview:
- Sits between the core's load/store stage and the dual-port word memory data port.
- The memory accepts only word-aligned accesses: asynchronous read, write on clock edge, zero returned for misaligned access.
- This block handles byte, halfword and word loads/stores with RISC-V funct3 encoding. Loads are sign/zero-extended; sub-word stores use read-modify-write.
- Handshakes with the core via valid/ready request and response channels.

Parameters:
- FAULT_ON_UNSELECTED, 1, when 1 an access whose address does not select the memory (mem_selected=0) completes with resp_fault=1 and no write; when 0 it completes normally with load data 0 and the store dropped.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept request
- req_rw  input  1  0=load, 1=store
- req_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
- req_address  input  32  byte address
- req_write_data  input  32  store data, LSB-aligned
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_read_data  output  32  extended load data (0 for stores/faults)
- resp_fault  output  1  misaligned, illegal funct3 or unselected access
- mem_rw  output  1  to memory rw
- mem_address  output  32  to memory address, always {addr[31:2],2'b00}
- mem_write_data  output  32  to memory write_data
- mem_read_data  input  32  from memory read_data (combinational)
- mem_selected  input  1  from memory selected

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - req_ready=1, resp_valid=0, resp_read_data=0, resp_fault=0.
  - mem_rw=0, mem_address=0, mem_write_data=0.
- Reset mid-operation aborts immediately. No memory write occurs in any cycle where rst is high.
- States are IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture rw, funct3, address and write data.
  - Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) or illegal funct3 (011, 110, 111; or store with funct3[2]=1) -> RESP with fault=1. No memory cycle is issued.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- RD:
  - Drive mem_address and mem_rw=0.
  - At the edge, latch mem_read_data and mem_selected.
  - If unselected: FAULT_ON_UNSELECTED=1 -> RESP with fault; FAULT_ON_UNSELECTED=0 -> RESP, a load returns 0 and a store is dropped.
  - Selected load -> RESP with extended data.
  - Selected sub-word store -> WR with merged word: byte lane addr[1:0], or halfword lane addr[1]; other lanes keep the read value.
- WR:
  - Drive mem_rw=1 only if mem_selected=1 (otherwise mem_rw=0).
  - mem_write_data is the merged word (sub-word) or the captured data (SW).
  - Exactly one write cycle; then RESP.
  - Unselected follows the same rule as in RD.
- RESP:
  - resp_valid=1; data and fault stay stable until resp_ready.
  - On resp_ready -> IDLE, and resp_valid drops the next cycle.
  - req_ready=0 in all non-IDLE states. No new request is accepted in the same cycle a response completes.
- mem_rw=0 in every state except WR.
- Load extension:
  - LB/LBU select the byte at addr[1:0].
  - LH/LHU select the half at addr[1].
  - Signed variants replicate bit 7/15; unsigned variants zero-fill.
- Latency (request accept edge to resp_valid):
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Fault detected in IDLE: 1 cycle.
- Back-to-back operation: a store followed by a load to the same word must return the new data, because the write completes before RD of the next request.

Test Plan:
- Memory word 0x80000010=0x8899AABB, LB at 0x80000011 -> resp_read_data=0xFFFFFFAA, fault=0, resp_valid 2 cycles after accept. LBU same address -> 0x000000AA.
- SB 0x5C to 0x80000012 over 0x11223344 -> exactly one mem_rw=1 cycle with write data 0x115C3344. Following LW returns 0x115C3344; resp_valid 3 cycles after accept.
- SH at 0x80000003 and LW at 0x80000002 -> resp_fault=1 after 1 cycle, mem_rw never asserted, memory unchanged.
- SW 0xDEADBEEF to 0x00000100 (mem_selected=0), FAULT_ON_UNSELECTED=1 -> fault=1, no write. With parameter=0 -> fault=0, no write; LW returns 0.
- Hold resp_ready=0 for 5 cycles after an LH of 0x8001 -> resp_valid and resp_read_data=0xFFFF8001 stable, req_ready=0. Release -> IDLE next cycle.
- Assert rst during WR of an SB -> no write that cycle, all outputs at reset values, next request serviced normally.
